// File: rtl/tile_map_pkg.sv
// Shared types and defaults for the scrolling tile map background.
// Tile ID encoding, staging FSM states, default geometry, bring-up pattern.
package tile_map_pkg;

  typedef enum logic [2:0] {
    EMPTY    = 3'd0,
    BRICK    = 3'd1,
    GROUND   = 3'd2,
    QUESTION = 3'd3,
    USED     = 3'd4
  } tile_id_t;

  typedef enum logic {
    ST_EMPTY = 1'b0,
    ST_FULL  = 1'b1
  } stage_state_t;

  localparam int DEF_COLS     = 14;
  localparam int DEF_ROWS     = 11;
  localparam int DEF_ID_W     = 3;
  localparam int DEF_TILE_PX  = 40;
  localparam int DEF_ORIGIN_X = 120;
  localparam int DEF_ORIGIN_Y = 40;

  localparam int PAT_B0_COL  = 5;
  localparam int PAT_B0_ROW  = 10;
  localparam int PAT_B1_COL  = 6;
  localparam int PAT_B1_ROWA = 9;
  localparam int PAT_B1_ROWB = 10;
  localparam int PAT_Q_COL   = 0;
  localparam int PAT_Q_ROW   = 0;

endpackage

// File: rtl/tile_coord_calc.sv
// Stage-1 pixel to tile mapping: subtract origin, add fine scroll, div/mod.
// In: i_draw_x/i_draw_y/i_fine_x. Out: o_col/o_row/o_px_x/o_px_y/o_in_win.
module tile_coord_calc
  import tile_map_pkg::*;
#(
  parameter int COLS     = DEF_COLS,
  parameter int ROWS     = DEF_ROWS,
  parameter int TILE_PX  = DEF_TILE_PX,
  parameter int ORIGIN_X = DEF_ORIGIN_X,
  parameter int ORIGIN_Y = DEF_ORIGIN_Y,
  parameter int CW       = $clog2(COLS),
  parameter int RW       = $clog2(ROWS),
  parameter int FX_W     = $clog2(TILE_PX)
) (
  input  logic [9:0]      i_draw_x,
  input  logic [9:0]      i_draw_y,
  input  logic [FX_W-1:0] i_fine_x,
  output logic [CW-1:0]   o_col,
  output logic [RW-1:0]   o_row,
  output logic [FX_W-1:0] o_px_x,
  output logic [FX_W-1:0] o_px_y,
  output logic            o_in_win
);

  localparam logic [10:0] TPX  = 11'(TILE_PX);
  localparam logic [10:0] X_LO = 11'(ORIGIN_X);
  // The last held column is only a scroll-in margin, never a full column.
  localparam logic [10:0] X_HI = 11'(ORIGIN_X + (COLS - 1) * TILE_PX);
  localparam logic [10:0] Y_LO = 11'(ORIGIN_Y);
  localparam logic [10:0] Y_HI = 11'(ORIGIN_Y + ROWS * TILE_PX);

  logic [10:0] w_dx;
  logic [10:0] w_dy;
  logic [10:0] w_ex;
  logic [10:0] w_ey;
  logic        w_in_x;
  logic        w_in_y;

  always_comb begin
    w_dx   = {1'b0, i_draw_x};
    w_dy   = {1'b0, i_draw_y};
    w_ex   = w_dx - X_LO + {{(11 - FX_W){1'b0}}, i_fine_x};
    w_ey   = w_dy - Y_LO;
    w_in_x = (w_dx >= X_LO) && (w_dx < X_HI);
    w_in_y = (w_dy >= Y_LO) && (w_dy < Y_HI);
    o_in_win = w_in_x && w_in_y;
    o_col  = '0;
    o_row  = '0;
    o_px_x = '0;
    o_px_y = '0;
    if (o_in_win) begin
      o_col  = CW'(w_ex / TPX);
      o_row  = RW'(w_ey / TPX);
      o_px_x = FX_W'(w_ex % TPX);
      o_px_y = FX_W'(w_ey % TPX);
    end
  end

endmodule

// File: rtl/tile_map_scroller.sv
// Scrolling tile map: column staging, 1-px scroll, tile writes, 2-cycle lookup.
// Build with TILE_MAP_INIT_PATTERN_EN to load the bring-up pattern on reset.
module tile_map_scroller
  import tile_map_pkg::*;
#(
  parameter int COLS     = DEF_COLS,
  parameter int ROWS     = DEF_ROWS,
  parameter int ID_W     = DEF_ID_W,
  parameter int TILE_PX  = DEF_TILE_PX,
  parameter int ORIGIN_X = DEF_ORIGIN_X,
  parameter int ORIGIN_Y = DEF_ORIGIN_Y,
  parameter int CW       = $clog2(COLS),
  parameter int RW       = $clog2(ROWS),
  parameter int FX_W     = $clog2(TILE_PX)
) (
  input  logic                 i_clk,
  input  logic                 i_reset,
  input  logic                 i_col_valid,
  input  logic [ROWS*ID_W-1:0] i_col_data,
  output logic                 o_col_ready,
  input  logic                 i_scroll,
  output logic                 o_scroll_stall,
  output logic [FX_W-1:0]      o_fine_x,
  input  logic                 i_wr_en,
  input  logic [CW-1:0]        i_wr_col,
  input  logic [RW-1:0]        i_wr_row,
  input  logic [ID_W-1:0]      i_wr_id,
  input  logic [9:0]           i_draw_x,
  input  logic [9:0]           i_draw_y,
  output logic [ID_W-1:0]      o_tile_id,
  output logic [FX_W-1:0]      o_tile_px_x,
  output logic [FX_W-1:0]      o_tile_px_y,
  output logic                 o_tile_valid
);

  stage_state_t r_state;
  stage_state_t w_state_nxt;

  logic [ROWS*ID_W-1:0] r_staged;
  logic [FX_W-1:0]      r_fine_x;
  logic [FX_W-1:0]      w_fine_x_nxt;
  logic                 w_at_end;
  logic                 w_shift;
  logic                 w_stall;
  logic                 w_accept;

  logic [COLS-1:0][ROWS-1:0][ID_W-1:0] r_grid;
  logic [COLS-1:0][ROWS-1:0][ID_W-1:0] w_grid_nxt;
  logic [COLS-1:0][ROWS-1:0][ID_W-1:0] w_grid_init;

  logic          w_wr_ok;
  logic [CW-1:0] w_wr_tgt;

  logic [CW-1:0]   w_c_col;
  logic [RW-1:0]   w_c_row;
  logic [FX_W-1:0] w_c_px_x;
  logic [FX_W-1:0] w_c_px_y;
  logic            w_c_in;

  logic [CW-1:0]   r_s1_col;
  logic [RW-1:0]   r_s1_row;
  logic [FX_W-1:0] r_s1_px_x;
  logic [FX_W-1:0] r_s1_px_y;
  logic            r_s1_valid;

  logic [ID_W-1:0] r_tile_id;
  logic [FX_W-1:0] r_px_x;
  logic [FX_W-1:0] r_px_y;
  logic            r_valid;

  // Scroll and staging control.
  always_comb begin
    w_state_nxt  = r_state;
    w_fine_x_nxt = r_fine_x;
    w_accept     = 1'b0;
    w_shift      = 1'b0;
    w_stall      = 1'b0;
    w_at_end     = (r_fine_x == FX_W'(TILE_PX - 1));
    if (i_scroll) begin
      if (!w_at_end) begin
        w_fine_x_nxt = r_fine_x + FX_W'(1);
      end else if (r_state == ST_FULL) begin
        w_shift      = 1'b1;
        w_fine_x_nxt = '0;
      end else begin
        w_stall = 1'b1;
      end
    end
    unique case (r_state)
      ST_EMPTY: begin
        if (i_col_valid) begin
          w_accept    = 1'b1;
          w_state_nxt = ST_FULL;
        end
      end
      // A new offer arriving with the shift waits for the EMPTY cycle.
      ST_FULL: begin
        if (w_shift) w_state_nxt = ST_EMPTY;
      end
      default: w_state_nxt = ST_EMPTY;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) r_state <= ST_EMPTY;
    else         r_state <= w_state_nxt;
  end

  // Writes are addressed in pre-shift numbering, so follow the shift left.
  always_comb begin
    w_wr_tgt = w_shift ? (i_wr_col - CW'(1)) : i_wr_col;
    w_wr_ok  = i_wr_en
            && (32'(i_wr_col) < COLS)
            && (32'(i_wr_row) < ROWS)
            && !(w_shift && (i_wr_col == '0));
  end

  always_comb begin
    w_grid_nxt = r_grid;
    if (w_shift) begin
      for (int c = 0; c < COLS - 1; c++) begin
        w_grid_nxt[c] = r_grid[c+1];
      end
      for (int r = 0; r < ROWS; r++) begin
        w_grid_nxt[COLS-1][r] = r_staged[r*ID_W +: ID_W];
      end
    end
    if (w_wr_ok) w_grid_nxt[w_wr_tgt][i_wr_row] = i_wr_id;
  end

  always_comb begin
    w_grid_init = '0;
`ifdef TILE_MAP_INIT_PATTERN_EN
    w_grid_init[PAT_B0_COL][PAT_B0_ROW]  = ID_W'(BRICK);
    w_grid_init[PAT_B1_COL][PAT_B1_ROWA] = ID_W'(BRICK);
    w_grid_init[PAT_B1_COL][PAT_B1_ROWB] = ID_W'(BRICK);
    w_grid_init[PAT_Q_COL][PAT_Q_ROW]    = ID_W'(QUESTION);
`endif
  end

  tile_coord_calc #(
    .COLS     (COLS),
    .ROWS     (ROWS),
    .TILE_PX  (TILE_PX),
    .ORIGIN_X (ORIGIN_X),
    .ORIGIN_Y (ORIGIN_Y),
    .CW       (CW),
    .RW       (RW),
    .FX_W     (FX_W)
  ) u_calc (
    .i_draw_x (i_draw_x),
    .i_draw_y (i_draw_y),
    .i_fine_x (r_fine_x),
    .o_col    (w_c_col),
    .o_row    (w_c_row),
    .o_px_x   (w_c_px_x),
    .o_px_y   (w_c_px_y),
    .o_in_win (w_c_in)
  );

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_staged   <= '0;
      r_fine_x   <= '0;
      r_grid     <= w_grid_init;
      r_s1_col   <= '0;
      r_s1_row   <= '0;
      r_s1_px_x  <= '0;
      r_s1_px_y  <= '0;
      r_s1_valid <= 1'b0;
      r_tile_id  <= '0;
      r_px_x     <= '0;
      r_px_y     <= '0;
      r_valid    <= 1'b0;
    end else begin
      if (w_accept) r_staged <= i_col_data;
      r_fine_x   <= w_fine_x_nxt;
      r_grid     <= w_grid_nxt;
      r_s1_col   <= w_c_col;
      r_s1_row   <= w_c_row;
      r_s1_px_x  <= w_c_px_x;
      r_s1_px_y  <= w_c_px_y;
      r_s1_valid <= w_c_in;
      // Stage 2 sees the grid as of now, including last cycle's updates.
      r_tile_id  <= r_s1_valid ? r_grid[r_s1_col][r_s1_row] : '0;
      r_px_x     <= r_s1_px_x;
      r_px_y     <= r_s1_px_y;
      r_valid    <= r_s1_valid;
    end
  end

  assign o_col_ready    = (r_state == ST_EMPTY);
  assign o_scroll_stall = w_stall & ~i_reset;
  assign o_fine_x       = r_fine_x;
  assign o_tile_id      = r_tile_id;
  assign o_tile_px_x    = r_px_x;
  assign o_tile_px_y    = r_px_y;
  assign o_tile_valid   = r_valid;

endmodule
